// File: rtl/sprite_sched.sv
// Four-entry sprite scheduler: picks the highest-priority sprite covering the
// scan pixel and drives the shared bitmap ROM, with per-sprite frame animation.
module sprite_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        video_on,
   input  logic        frame_tick,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_sel,
   input  logic [31:0] cfg_data,
   output logic [7:0]  rom_addr,
   output logic [3:0]  rom_index,
   output logic        rom_inv,
   output logic        rom_en,
   output logic [1:0]  hit_id
);

   logic [9:0] x_q      [4];
   logic [9:0] y_q      [4];
   logic [3:0] base_q   [4];
   logic [1:0] nfm1_q   [4];
   logic [3:0] period_q [4];
   logic       inv_q    [4];
   logic       en_q     [4];
   logic [1:0] phase_q  [4];
   logic [3:0] div_q    [4];

   logic [3:0] hit;
   logic [9:0] dx       [4];
   logic [9:0] dy       [4];
   logic [3:0] idx      [4];
   logic       win;
   logic [1:0] win_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            x_q[i]      <= '0;
            y_q[i]      <= '0;
            base_q[i]   <= '0;
            nfm1_q[i]   <= '0;
            period_q[i] <= '0;
            inv_q[i]    <= 1'b0;
            en_q[i]     <= 1'b0;
            phase_q[i]  <= '0;
            div_q[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            // A write to an entry overrides any animation step in the same cycle
            if (cfg_we && (cfg_sel == i[1:0])) begin
               x_q[i]      <= cfg_data[9:0];
               y_q[i]      <= cfg_data[19:10];
               base_q[i]   <= cfg_data[23:20];
               nfm1_q[i]   <= cfg_data[25:24];
               period_q[i] <= cfg_data[29:26];
               inv_q[i]    <= cfg_data[30];
               en_q[i]     <= cfg_data[31];
               phase_q[i]  <= '0;
               div_q[i]    <= '0;
            end else if (frame_tick && en_q[i] && (period_q[i] != 4'd0)) begin
               if ((div_q[i] + 4'd1) == period_q[i]) begin
                  div_q[i]   <= '0;
                  phase_q[i] <= (phase_q[i] == nfm1_q[i]) ? 2'd0 : phase_q[i] + 2'd1;
               end else begin
                  div_q[i] <= div_q[i] + 4'd1;
               end
            end
         end
      end
   end

   // 11-bit compare so a sprite near the right edge never wraps to column 0
   always_comb begin
      hit = '0;
      for (int i = 0; i < 4; i++) begin
         hit[i] = en_q[i]
                  && ({1'b0, hcount} >= {1'b0, x_q[i]})
                  && ({1'b0, hcount} <= ({1'b0, x_q[i]} + 11'd15))
                  && ({1'b0, vcount} >= {1'b0, y_q[i]})
                  && ({1'b0, vcount} <= ({1'b0, y_q[i]} + 11'd15));
         dx[i]  = hcount - x_q[i];
         dy[i]  = vcount - y_q[i];
         idx[i] = base_q[i] + {2'b00, phase_q[i]};
      end
   end

   always_comb begin
      win    = 1'b0;
      win_id = '0;
      for (int i = 3; i >= 0; i--) begin
         if (hit[i]) begin
            win    = 1'b1;
            win_id = i[1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr  <= '0;
         rom_index <= '0;
         rom_inv   <= 1'b0;
         rom_en    <= 1'b0;
         hit_id    <= '0;
      end else if (video_on && win) begin
         rom_addr  <= {dy[win_id][3:0], dx[win_id][3:0]};
         rom_index <= idx[win_id];
         rom_inv   <= inv_q[win_id];
         rom_en    <= 1'b1;
         hit_id    <= win_id;
      end else begin
         rom_addr  <= '0;
         rom_index <= '0;
         rom_inv   <= 1'b0;
         rom_en    <= 1'b0;
         hit_id    <= '0;
      end
   end

endmodule

// File: tb/tb_sprite_sched.sv
// Bench for sprite_sched: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_sprite_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  hcount = '0;
   logic [9:0]  vcount = '0;
   logic        video_on = 1'b0;
   logic        frame_tick = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_sel = '0;
   logic [31:0] cfg_data = '0;
   logic [7:0]  rom_addr;
   logic [3:0]  rom_index;
   logic        rom_inv;
   logic        rom_en;
   logic [1:0]  hit_id;

   int total = 0;
   int bad = 0;

   // Behavioural model state
   int mx [4], my [4], mbase [4], mnf [4], mper [4], minv [4], men [4], mph [4], mdiv [4];
   int e_addr, e_index, e_inv, e_en, e_id;

   sprite_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hcount     (hcount),
      .vcount     (vcount),
      .video_on   (video_on),
      .frame_tick (frame_tick),
      .cfg_we     (cfg_we),
      .cfg_sel    (cfg_sel),
      .cfg_data   (cfg_data),
      .rom_addr   (rom_addr),
      .rom_index  (rom_index),
      .rom_inv    (rom_inv),
      .rom_en     (rom_en),
      .hit_id     (hit_id)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(int x, int y, int base, int nfm1, int period,
                                      int inv, int en);
      logic [31:0] d;
      d = '0;
      d[9:0]   = x[9:0];
      d[19:10] = y[9:0];
      d[23:20] = base[3:0];
      d[25:24] = nfm1[1:0];
      d[29:26] = period[3:0];
      d[30]    = inv[0];
      d[31]    = en[0];
      return d;
   endfunction

   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         mx[i] = 0; my[i] = 0; mbase[i] = 0; mnf[i] = 0; mper[i] = 0;
         minv[i] = 0; men[i] = 0; mph[i] = 0; mdiv[i] = 0;
      end
      e_addr = 0; e_index = 0; e_inv = 0; e_en = 0; e_id = 0;
   endtask

   // One clock: model follows the edge, then outputs are compared on the falling edge
   task automatic step();
      int h, v, w;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         h = int'(hcount);
         v = int'(vcount);
         w = -1;
         for (int i = 0; i < 4; i++)
            if (w < 0 && men[i] != 0 && h >= mx[i] && h <= mx[i] + 15 &&
                v >= my[i] && v <= my[i] + 15)
               w = i;
         if (video_on && w >= 0) begin
            e_en = 1; e_id = w; e_inv = minv[w];
            e_addr = (v - my[w]) * 16 + (h - mx[w]);
            e_index = (mbase[w] + mph[w]) % 16;
         end else begin
            e_en = 0; e_id = 0; e_inv = 0; e_addr = 0; e_index = 0;
         end
         for (int i = 0; i < 4; i++) begin
            if (cfg_we && int'(cfg_sel) == i) begin
               mx[i] = int'(cfg_data[9:0]);     my[i] = int'(cfg_data[19:10]);
               mbase[i] = int'(cfg_data[23:20]); mnf[i] = int'(cfg_data[25:24]);
               mper[i] = int'(cfg_data[29:26]);  minv[i] = int'(cfg_data[30]);
               men[i] = int'(cfg_data[31]);      mph[i] = 0; mdiv[i] = 0;
            end else if (frame_tick && men[i] != 0 && mper[i] != 0) begin
               if (mdiv[i] + 1 == mper[i]) begin
                  mdiv[i] = 0;
                  mph[i] = (mph[i] == mnf[i]) ? 0 : mph[i] + 1;
               end else begin
                  mdiv[i] = mdiv[i] + 1;
               end
            end
         end
      end
      @(negedge clk);
      cmp("model.rom_en", 32'(rom_en), 32'(e_en));
      cmp("model.hit_id", 32'(hit_id), 32'(e_id));
      cmp("model.rom_addr", 32'(rom_addr), 32'(e_addr));
      cmp("model.rom_index", 32'(rom_index), 32'(e_index));
      cmp("model.rom_inv", 32'(rom_inv), 32'(e_inv));
   endtask

   task automatic scan(int h, int v, logic vo, logic ft);
      cfg_we = 1'b0;
      hcount = h[9:0];
      vcount = v[9:0];
      video_on = vo;
      frame_tick = ft;
      step();
   endtask

   task automatic wr(int sel, logic [31:0] d);
      cfg_we = 1'b1;
      cfg_sel = sel[1:0];
      cfg_data = d;
      frame_tick = 1'b0;
      video_on = 1'b0;
      step();
      cfg_we = 1'b0;
   endtask

   int seq [9] = '{6, 6, 7, 7, 8, 8, 9, 9, 6};

   initial begin
      model_reset();
      step();
      step();
      cmp("reset.rom_en", 32'(rom_en), 32'd0);
      cmp("reset.rom_addr", 32'(rom_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic config and addressing
      wr(0, mk(100, 50, 4, 1, 0, 0, 1));
      scan(100, 50, 1'b1, 1'b0);
      cmp("cfg.en", 32'(rom_en), 32'd1);
      cmp("cfg.addr0", 32'(rom_addr), 32'h00);
      cmp("cfg.index", 32'(rom_index), 32'd4);
      cmp("cfg.hit_id", 32'(hit_id), 32'd0);
      scan(115, 65, 1'b1, 1'b0);
      cmp("cfg.addrff", 32'(rom_addr), 32'hFF);
      scan(116, 50, 1'b1, 1'b0);
      cmp("cfg.outside_en", 32'(rom_en), 32'd0);
      cmp("cfg.outside_addr", 32'(rom_addr), 32'd0);

      // Priority
      wr(0, mk(100, 50, 4, 1, 0, 0, 0));
      wr(1, mk(100, 50, 1, 0, 0, 0, 1));
      wr(2, mk(108, 50, 2, 0, 0, 0, 1));
      scan(110, 52, 1'b1, 1'b0);
      cmp("prio.hit_id", 32'(hit_id), 32'd1);
      cmp("prio.addr", 32'(rom_addr), 32'h2A);
      wr(1, mk(100, 50, 1, 0, 0, 0, 0));
      scan(110, 52, 1'b1, 1'b0);
      cmp("prio2.hit_id", 32'(hit_id), 32'd2);
      cmp("prio2.addr", 32'(rom_addr), 32'h22);

      // Animation: index before any tick, then after each of 8 ticks
      wr(2, mk(108, 50, 2, 0, 0, 0, 0));
      wr(0, mk(100, 50, 6, 3, 2, 0, 1));
      scan(100, 50, 1'b1, 1'b0);
      cmp("anim.idx0", 32'(rom_index), 32'(seq[0]));
      for (int k = 1; k <= 8; k++) begin
         scan(100, 50, 1'b1, 1'b1);
         scan(100, 50, 1'b1, 1'b0);
         cmp($sformatf("anim.idx%0d", k), 32'(rom_index), 32'(seq[k]));
      end

      // Collision of write and tick on sprite 0; sprite 3 ticks alongside
      wr(3, mk(200, 50, 1, 3, 1, 0, 1));
      for (int k = 0; k < 4; k++) scan(100, 50, 1'b1, 1'b1);
      scan(100, 50, 1'b1, 1'b0);
      cmp("coll.pre_idx", 32'(rom_index), 32'd8);
      cfg_we = 1'b1;
      cfg_sel = 2'd0;
      cfg_data = mk(100, 50, 6, 3, 2, 0, 1);
      frame_tick = 1'b1;
      step();
      cfg_we = 1'b0;
      scan(100, 50, 1'b1, 1'b0);
      cmp("coll.idx", 32'(rom_index), 32'd6);
      scan(200, 50, 1'b1, 1'b0);
      cmp("coll.s3_idx", 32'(rom_index), 32'd2);

      // Right edge, blanking, invert
      wr(3, mk(200, 50, 1, 3, 1, 0, 0));
      wr(0, mk(1015, 50, 3, 0, 0, 1, 1));
      scan(0, 50, 1'b1, 1'b0);
      cmp("edge.nowrap", 32'(rom_en), 32'd0);
      scan(1020, 50, 1'b1, 1'b0);
      cmp("edge.en", 32'(rom_en), 32'd1);
      cmp("edge.addr", 32'(rom_addr), 32'h05);
      cmp("edge.inv", 32'(rom_inv), 32'd1);
      scan(1020, 50, 1'b0, 1'b0);
      cmp("blank.en", 32'(rom_en), 32'd0);
      cmp("blank.inv", 32'(rom_inv), 32'd0);

      // Asynchronous reset while a sprite is being drawn
      scan(1020, 51, 1'b1, 1'b0);
      cmp("areset.pre_en", 32'(rom_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      cmp("areset.en", 32'(rom_en), 32'd0);
      cmp("areset.addr", 32'(rom_addr), 32'd0);
      cmp("areset.index", 32'(rom_index), 32'd0);
      cmp("areset.inv", 32'(rom_inv), 32'd0);
      cmp("areset.hit_id", 32'(hit_id), 32'd0);
      scan(1020, 51, 1'b1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      scan(1020, 51, 1'b1, 1'b0);
      cmp("areset.after_en", 32'(rom_en), 32'd0);
      wr(2, mk(1015, 50, 9, 0, 0, 0, 1));
      scan(1020, 51, 1'b1, 1'b0);
      cmp("areset.rewrite_id", 32'(hit_id), 32'd2);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            int x, y;
            x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1023))
                                            : int'($urandom_range(0, 240));
            y = int'($urandom_range(0, 240));
            cfg_we = 1'b1;
            cfg_sel = 2'($urandom_range(0, 3));
            cfg_data = mk(x, y, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 4)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3) != 0));
         end else begin
            cfg_we = 1'b0;
         end
         hcount = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023))
                                              : 10'($urandom_range(0, 260));
         vcount = 10'($urandom_range(0, 260));
         video_on = ($urandom_range(0, 9) != 0);
         frame_tick = ($urandom_range(0, 4) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
